// File: rtl/core_pkg.sv
// Shared definitions for the core: funct3 access codes, MEM-stage FSM
// encoding, default parameters and the EX/MEM pipeline register layout.
package core_pkg;

   localparam int XLEN_DEFAULT    = 32;
   localparam int TIMEOUT_DEFAULT = 16;

   // funct3 access size / signedness codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // MEM-stage data-port FSM encoding
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   // EX/MEM pipeline register contents
   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] rs2;
      logic [31:0] pc_branch;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        zero;
   } ex_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the memory (slave).
//
// Handshake: the master raises dmem_req with dmem_we/addr/be/wdata and keeps
// all of them stable until the slave answers with dmem_ready = 1; the access
// completes in that cycle and dmem_rdata is valid only then. The master may
// withdraw a request only on an abort (timeout) or reset.
interface mem_stage_if #(
   parameter int XLEN = core_pkg::XLEN_DEFAULT
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ready;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/mem_stage_load_store_align.sv
// Combinational load/store lane logic: word address, byte enables, store
// lane replication, load lane selection with sign/zero extension, and the
// funct3 legality / alignment check.
module load_store_align
   import core_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        legal,
   output logic [31:0] word_addr,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);
   logic [1:0]  lane;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign lane      = addr[1:0];
   assign word_addr = {addr[31:2], 2'b00};
   assign byte_sel  = rdata[{lane, 3'b000} +: 8];
   assign half_sel  = rdata[{lane[1], 4'b0000} +: 16];

   // Store lanes: replicate data across the word, enables pick the lane
   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      if (is_store) begin
         case (funct3)
            F3_B: begin
               be    = 4'b0001 << lane;
               wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
               be    = lane[1] ? 4'b1100 : 4'b0011;
               wdata = {2{store_data[15:0]}};
            end
            default: begin
               be    = 4'b1111;
               wdata = store_data;
            end
         endcase
      end
   end

   // Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through
   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_BU:   load_data = {24'h0, byte_sel};
         F3_HU:   load_data = {16'h0, half_sel};
         default: load_data = rdata;
      endcase
   end

   // Legality: unsigned sizes are load-only; halfword/word need natural alignment
   always_comb begin
      case (funct3)
         F3_B:    legal = 1'b1;
         F3_H:    legal = ~addr[0];
         F3_W:    legal = (addr[1:0] == 2'b00);
         F3_BU:   legal = ~is_store;
         F3_HU:   legal = ~is_store & ~addr[0];
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage core: EX/MEM register, data-port FSM with wait
// timeout, MEM/WB register, and the MEM-side forwarding/branch outputs.
module mem_stage
   import core_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int XLEN    = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] ALU_OUT_EX,
   input  logic [XLEN-1:0] REG_DATA2_EX_FINAL,
   input  logic [4:0]      RD_EX,
   input  logic [2:0]      FUNCT3_EX,
   input  logic            RegWrite_EX,
   input  logic            MemtoReg_EX,
   input  logic            MemRead_EX,
   input  logic            MemWrite_EX,
   input  logic            Branch_EX,
   input  logic            ZERO_EX,
   input  logic [XLEN-1:0] PC_Branch_EX,
   input  logic            flush,
   mem_stage_if.master     dmem,
   output logic            stall,
   output logic            mem_err,
   output logic [XLEN-1:0] ALU_OUT_MEM,
   output logic [4:0]      RD_MEM,
   output logic            RegWrite_MEM,
   output logic            PCSrc_MEM,
   output logic [XLEN-1:0] PC_Branch_MEM,
   output logic [XLEN-1:0] MEM_DATA_WB,
   output logic [XLEN-1:0] ALU_OUT_WB,
   output logic [4:0]      RD_WB,
   output logic            RegWrite_WB,
   output logic            MemtoReg_WB,
   output logic [0:0]      fsm_state
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   ex_mem_t          ex_mem;
   ex_mem_t          ex_next;
   logic [0:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             access_legal;
   logic             mem_op;
   logic             access_ok;
   logic             access_bad;
   logic             timeout_abort;
   logic             wb_kill;
   logic [31:0]      load_data;

   // EX/MEM next value: EX results, or an all-zero bubble on flush
   always_comb begin
      ex_next = '0;
      if (!flush) begin
         ex_next.alu_out    = ALU_OUT_EX;
         ex_next.rs2        = REG_DATA2_EX_FINAL;
         ex_next.pc_branch  = PC_Branch_EX;
         ex_next.rd         = RD_EX;
         ex_next.funct3     = FUNCT3_EX;
         ex_next.reg_write  = RegWrite_EX;
         ex_next.mem_to_reg = MemtoReg_EX;
         ex_next.mem_read   = MemRead_EX;
         ex_next.mem_write  = MemWrite_EX;
         ex_next.branch     = Branch_EX;
         ex_next.zero       = ZERO_EX;
      end
   end

   // EX/MEM register: holds while stalled (stall wins over flush)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ex_mem <= '0;
      else if (!stall) ex_mem <= ex_next;
   end

   load_store_align u_align (
      .addr       (ex_mem.alu_out),
      .funct3     (ex_mem.funct3),
      .is_store   (ex_mem.mem_write),
      .store_data (ex_mem.rs2),
      .rdata      (dmem.dmem_rdata),
      .legal      (access_legal),
      .word_addr  (dmem.dmem_addr),
      .be         (dmem.dmem_be),
      .wdata      (dmem.dmem_wdata),
      .load_data  (load_data)
   );

   // Read+write together is treated as a write via is_store above
   assign mem_op        = ex_mem.mem_read | ex_mem.mem_write;
   assign access_ok     = mem_op & access_legal;
   assign access_bad    = mem_op & ~access_legal;
   assign timeout_abort = (state == S_WAIT) & ~dmem.dmem_ready
                        & (wait_cnt == CNT_W'(TIMEOUT));

   assign stall         = access_ok & ~dmem.dmem_ready & ~timeout_abort;
   assign mem_err       = access_bad | timeout_abort;
   assign dmem.dmem_req = access_ok & ~timeout_abort;
   assign dmem.dmem_we  = ex_mem.mem_write;
   assign wb_kill       = stall | timeout_abort | access_bad;
   assign fsm_state     = state;

   assign ALU_OUT_MEM   = ex_mem.alu_out;
   assign RD_MEM        = ex_mem.rd;
   assign RegWrite_MEM  = ex_mem.reg_write;
   assign PCSrc_MEM     = ex_mem.branch & ex_mem.zero;
   assign PC_Branch_MEM = ex_mem.pc_branch;

   // Data-port FSM: counts wait cycles, leaves WAIT on completion or timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (access_ok && !dmem.dmem_ready) begin
                  state    <= S_WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (dmem.dmem_ready || timeout_abort) begin
                  state    <= S_IDLE;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // MEM/WB register: loads every cycle; stalls, aborts and bad accesses send a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MEM_DATA_WB <= '0;
         ALU_OUT_WB  <= '0;
         RD_WB       <= '0;
         RegWrite_WB <= 1'b0;
         MemtoReg_WB <= 1'b0;
      end else begin
         MEM_DATA_WB <= load_data;
         ALU_OUT_WB  <= ex_mem.alu_out;
         RD_WB       <= ex_mem.rd;
         RegWrite_WB <= ex_mem.reg_write & ~wb_kill;
         MemtoReg_WB <= ex_mem.mem_to_reg & ~wb_kill;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed instructions, a data-memory
// responder with configurable wait, and a monitor that pops expected
// memory requests and write-backs from scoreboard queues.
module tb_mem_stage;
   import core_pkg::*;

   localparam logic [5:0] C_NONE  = 6'b000000; // {rw, m2r, mr, mw, br, z}
   localparam logic [5:0] C_ALU   = 6'b100000;
   localparam logic [5:0] C_LOAD  = 6'b111000;
   localparam logic [5:0] C_STORE = 6'b000100;
   localparam logic [5:0] C_BR    = 6'b000011;
   localparam logic [5:0] C_BRNZ  = 6'b000010;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [31:0] alu_ex, rs2_ex, pcb_ex;
   logic [4:0]  rd_ex;
   logic [2:0]  f3_ex;
   logic        rw_ex, m2r_ex, mr_ex, mw_ex, br_ex, z_ex, flush;
   logic        stall, mem_err, regwrite_mem, pcsrc_mem, regwrite_wb, memtoreg_wb;
   logic [31:0] alu_mem, pcb_mem, mem_data_wb, alu_wb;
   logic [4:0]  rd_mem, rd_wb;
   logic [0:0]  fsm_state;

   mem_stage_if #(.XLEN(32)) dmem_bus ();

   mem_stage #(.TIMEOUT(16), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .ALU_OUT_EX(alu_ex), .REG_DATA2_EX_FINAL(rs2_ex), .RD_EX(rd_ex),
      .FUNCT3_EX(f3_ex), .RegWrite_EX(rw_ex), .MemtoReg_EX(m2r_ex),
      .MemRead_EX(mr_ex), .MemWrite_EX(mw_ex), .Branch_EX(br_ex),
      .ZERO_EX(z_ex), .PC_Branch_EX(pcb_ex), .flush(flush),
      .dmem(dmem_bus),
      .stall(stall), .mem_err(mem_err),
      .ALU_OUT_MEM(alu_mem), .RD_MEM(rd_mem), .RegWrite_MEM(regwrite_mem),
      .PCSrc_MEM(pcsrc_mem), .PC_Branch_MEM(pcb_mem),
      .MEM_DATA_WB(mem_data_wb), .ALU_OUT_WB(alu_wb), .RD_WB(rd_wb),
      .RegWrite_WB(regwrite_wb), .MemtoReg_WB(memtoreg_wb),
      .fsm_state(fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [68:0] exp_req_q[$]; // {we, addr, be, wdata}
   logic [69:0] exp_wb_q[$];  // {memtoreg, rd, alu, data}
   int stall_cnt = 0;
   int err_cnt   = 0;
   int req_cnt   = 0;
   int resp_wait = 0;
   logic [31:0] resp_rdata = 32'h0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- memory responder ----------------
   int waited = 0;
   always begin
      @(posedge clk);
      #2;
      if (dmem_bus.dmem_req === 1'b1) begin
         if (waited >= resp_wait) begin
            dmem_bus.dmem_ready = 1'b1;
            dmem_bus.dmem_rdata = resp_rdata;
            waited = 0;
         end else begin
            dmem_bus.dmem_ready = 1'b0;
            dmem_bus.dmem_rdata = 32'h0;
            waited++;
         end
      end else begin
         dmem_bus.dmem_ready = 1'b0;
         dmem_bus.dmem_rdata = 32'h0;
         waited = 0;
      end
   end

   // ---------------- monitor ----------------
   logic        prev_stall = 1'b0;
   logic        prev_wait  = 1'b0;
   logic [68:0] prev_req_sig;
   logic [31:0] prev_alu_mem;
   always @(negedge clk) begin
      logic [68:0] cur_req, exp_r;
      logic [69:0] cur_wb, exp_w;
      if (reset) begin
         prev_stall = 1'b0;
         prev_wait  = 1'b0;
      end else begin
         cur_req = {dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata};
         if (stall) stall_cnt++;
         if (mem_err) err_cnt++;
         if (dmem_bus.dmem_req) req_cnt++;
         if (prev_stall)
            check("wb_bubble", 128'({regwrite_wb, memtoreg_wb}), 128'(2'b00));
         if (prev_wait && dmem_bus.dmem_req) begin
            check("req_stable", 128'(cur_req), 128'(prev_req_sig));
            check("alu_mem_stable", 128'(alu_mem), 128'(prev_alu_mem));
         end
         if (dmem_bus.dmem_req && dmem_bus.dmem_ready) begin
            if (exp_req_q.size() == 0) check("req_unexpected", 128'(1), 128'(0));
            else begin
               exp_r = exp_req_q.pop_front();
               if (!exp_r[68]) cur_req[31:0] = exp_r[31:0]; // load: wdata unused
               check("dmem_req", 128'(cur_req), 128'(exp_r));
            end
         end
         if (regwrite_wb) begin
            if (exp_wb_q.size() == 0) check("wb_unexpected", 128'(1), 128'(0));
            else begin
               exp_w  = exp_wb_q.pop_front();
               cur_wb = {memtoreg_wb, rd_wb, alu_wb, mem_data_wb};
               if (!exp_w[69]) cur_wb[31:0] = exp_w[31:0]; // ALU op: load data unused
               check("wb", 128'(cur_wb), 128'(exp_w));
            end
         end
         prev_stall   = stall;
         prev_wait    = dmem_bus.dmem_req & ~dmem_bus.dmem_ready;
         prev_req_sig = cur_req;
         prev_alu_mem = alu_mem;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [5:0] ctl, input logic fl,
                        input logic [31:0] pcb);
      alu_ex = alu; rs2_ex = rs2; rd_ex = rd; f3_ex = f3; pcb_ex = pcb; flush = fl;
      {rw_ex, m2r_ex, mr_ex, mw_ex, br_ex, z_ex} = ctl;
   endtask

   // Present an instruction and return #1 after the edge that captured it
   task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [5:0] ctl, input logic fl,
                        input logic [31:0] pcb);
      int n;
      drive(alu, rs2, rd, f3, ctl, fl, pcb);
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!stall) break;
      end
      if (n == 100) check("issue_timeout", 128'(1), 128'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      issue(32'h0, 32'h0, 5'd0, 3'd0, C_NONE, 1'b0, 32'h0);
      issue(32'h0, 32'h0, 5'd0, 3'd0, C_NONE, 1'b0, 32'h0);
   endtask

   task automatic end_test(input string name, input int e_stall, input int e_err, input int e_req);
      check({name, "_stall_cycles"}, 128'(stall_cnt), 128'(e_stall));
      check({name, "_err_cycles"}, 128'(err_cnt), 128'(e_err));
      check({name, "_req_cycles"}, 128'(req_cnt), 128'(e_req));
      stall_cnt = 0; err_cnt = 0; req_cnt = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      drive(32'h0, 32'h0, 5'd0, 3'd0, C_NONE, 1'b0, 32'h0);
      dmem_bus.dmem_ready = 1'b0;
      dmem_bus.dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctl", 128'({stall, mem_err, dmem_bus.dmem_req, fsm_state}), 128'(0));
      check("reset_mem", 128'({alu_mem, rd_mem, regwrite_mem, pcsrc_mem, pcb_mem}), 128'(0));
      check("reset_wb", 128'({mem_data_wb, alu_wb, rd_wb, regwrite_wb, memtoreg_wb}), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      stall_cnt = 0; err_cnt = 0; req_cnt = 0;

      // ALU op, branches, flush
      exp_wb_q.push_back({1'b0, 5'd3, 32'h55, 32'h0});
      issue(32'h55, 32'h0, 5'd3, 3'd0, C_ALU, 1'b0, 32'h0);
      check("fwd_alu", 128'({alu_mem, rd_mem, regwrite_mem}), 128'({32'h55, 5'd3, 1'b1}));
      issue(32'h0, 32'h0, 5'd0, 3'd0, C_BR, 1'b0, 32'h8000_0040);
      check("branch_taken", 128'({pcsrc_mem, pcb_mem}), 128'({1'b1, 32'h8000_0040}));
      issue(32'h0, 32'h0, 5'd0, 3'd0, C_BRNZ, 1'b0, 32'h8000_0080);
      check("branch_nz", 128'({pcsrc_mem, pcb_mem}), 128'({1'b0, 32'h8000_0080}));
      issue(32'h66, 32'h0, 5'd4, 3'd0, C_ALU, 1'b1, 32'h1234);
      check("flush_bubble", 128'({regwrite_mem, rd_mem, alu_mem, pcb_mem}), 128'(0));
      drain();
      end_test("alu", 0, 0, 0);

      // zero-wait LW
      resp_wait = 0; resp_rdata = 32'hDEAD_BEEF;
      exp_req_q.push_back({1'b0, 32'h100, 4'hF, 32'h0});
      exp_wb_q.push_back({1'b1, 5'd5, 32'h100, 32'hDEAD_BEEF});
      issue(32'h100, 32'h0, 5'd5, F3_W, C_LOAD, 1'b0, 32'h0);
      drain();
      end_test("lw", 0, 0, 1);

      // LB / LBU at lane 3
      resp_rdata = 32'h8012_3456;
      exp_req_q.push_back({1'b0, 32'h100, 4'hF, 32'h0});
      exp_wb_q.push_back({1'b1, 5'd6, 32'h103, 32'hFFFF_FF80});
      issue(32'h103, 32'h0, 5'd6, F3_B, C_LOAD, 1'b0, 32'h0);
      exp_req_q.push_back({1'b0, 32'h100, 4'hF, 32'h0});
      exp_wb_q.push_back({1'b1, 5'd7, 32'h103, 32'h0000_0080});
      issue(32'h103, 32'h0, 5'd7, F3_BU, C_LOAD, 1'b0, 32'h0);
      drain();
      end_test("lb", 0, 0, 2);

      // stores: SH upper lane, SB lane 1, SW
      exp_req_q.push_back({1'b1, 32'h100, 4'b1100, 32'hABCD_ABCD});
      issue(32'h102, 32'h1234_ABCD, 5'd0, F3_H, C_STORE, 1'b0, 32'h0);
      exp_req_q.push_back({1'b1, 32'h100, 4'b0010, 32'hEEEE_EEEE});
      issue(32'h101, 32'h0000_00EE, 5'd0, F3_B, C_STORE, 1'b0, 32'h0);
      exp_req_q.push_back({1'b1, 32'h200, 4'b1111, 32'hCAFE_F00D});
      issue(32'h200, 32'hCAFE_F00D, 5'd0, F3_W, C_STORE, 1'b0, 32'h0);
      drain();
      end_test("store", 0, 0, 3);

      // LH at lane 2 with three wait cycles
      resp_wait = 3; resp_rdata = 32'h8001_7FFF;
      exp_req_q.push_back({1'b0, 32'h104, 4'hF, 32'h0});
      exp_wb_q.push_back({1'b1, 5'd8, 32'h106, 32'hFFFF_8001});
      issue(32'h106, 32'h0, 5'd8, F3_H, C_LOAD, 1'b0, 32'h0);
      drain();
      end_test("wait3", 3, 0, 4);

      // misaligned and illegal accesses
      resp_wait = 0;
      issue(32'h101, 32'h0, 5'd9, F3_W, C_LOAD, 1'b0, 32'h0);
      issue(32'h200, 32'h0, 5'd10, 3'b011, C_LOAD, 1'b0, 32'h0);
      issue(32'h101, 32'h1, 5'd0, F3_H, C_STORE, 1'b0, 32'h0);
      issue(32'h200, 32'h1, 5'd0, F3_BU, C_STORE, 1'b0, 32'h0);
      drain();
      end_test("bad", 0, 4, 0);

      // timeout with ready held low
      resp_wait = 1000;
      issue(32'h300, 32'h0, 5'd11, F3_W, C_LOAD, 1'b0, 32'h0);
      drain();
      end_test("timeout", 16, 1, 16);

      // port recovers after a timeout
      resp_wait = 0; resp_rdata = 32'h0102_0304;
      exp_req_q.push_back({1'b0, 32'h304, 4'hF, 32'h0});
      exp_wb_q.push_back({1'b1, 5'd12, 32'h304, 32'h0102_0304});
      issue(32'h304, 32'h0, 5'd12, F3_W, C_LOAD, 1'b0, 32'h0);
      drain();
      end_test("after_timeout", 0, 0, 1);

      // reset asserted while waiting
      resp_wait = 1000;
      issue(32'h400, 32'h0, 5'd13, F3_W, C_LOAD, 1'b0, 32'h0);
      drive(32'h0, 32'h0, 5'd0, 3'd0, C_NONE, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_reset_wait", 128'({stall, dmem_bus.dmem_req, fsm_state}), 128'(3'b111));
      #1 reset = 1'b1;
      #1;
      check("reset_in_wait", 128'({stall, dmem_bus.dmem_req, fsm_state, mem_err}), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      stall_cnt = 0; err_cnt = 0; req_cnt = 0;
      resp_wait = 0;
      drain();
      end_test("post_reset", 0, 0, 0);

      check("exp_req_left", 128'(exp_req_q.size()), 128'(0));
      check("exp_wb_left", 128'(exp_wb_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop if the run ever wedges
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Combines the EX/MEM pipeline register with the load/store unit of the 5-stage RISC-V core.
- Consumes the execute-stage results: ALU result, forwarded rs2 data, rd, funct3, control bits, branch target and zero flag.
- Drives a ready/valid data-memory port and stalls while waiting on the port.
- Produces the MEM/WB register contents and the MEM-side forwarding sources (ALU_OUT_MEM, RD_MEM, RegWrite_MEM).

Parameters:
- TIMEOUT, 16: maximum wait cycles on dmem_ready before the access is aborted with an error.
- XLEN, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ALU_OUT_EX  in  32  ALU result; the effective address for loads and stores.
- REG_DATA2_EX_FINAL  in  32  forwarded rs2 value; the store data.
- RD_EX  in  5  destination register.
- FUNCT3_EX  in  3  access size and signedness.
- RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ZERO_EX  in  1 each  control and flag bits.
- PC_Branch_EX  in  32  branch target.
- flush  in  1  loads a bubble into EX/MEM instead of the EX values.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address (addr[1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_rdata  in  32  read data; valid when dmem_ready = 1.
- dmem_ready  in  1  access completes this cycle.
- stall  out  1  freeze PC, IF/ID and ID/EX.
- mem_err  out  1  one-cycle pulse on a misaligned, illegal or timed-out access.
- ALU_OUT_MEM  out  32  EX/MEM ALU result; forwarding source.
- RD_MEM  out  5  EX/MEM rd; forwarding source.
- RegWrite_MEM  out  1  EX/MEM RegWrite; forwarding source.
- PCSrc_MEM  out  1  Branch & ZERO from EX/MEM.
- PC_Branch_MEM  out  32  EX/MEM branch target.
- MEM_DATA_WB  out  32  extended load data.
- ALU_OUT_WB  out  32  ALU result in MEM/WB.
- RD_WB  out  5  rd in MEM/WB.
- RegWrite_WB, MemtoReg_WB  out  1 each  MEM/WB control bits.

Behaviour:
- Reset (asynchronous): every register and output clears to 0; FSM goes to IDLE; wait counter = 0.
- EX/MEM register:
  - Loads on clk when stall = 0.
  - When flush = 1 and stall = 0, loads all zeros (a bubble).
  - When stall = 1, holds its contents. stall has priority over flush.
- Access present: mem_op = MemRead_MEM | MemWrite_MEM. If both bits are set, the access is treated as a write.
- Legality check, in MEM on the held address a = ALU_OUT_MEM:
  - Legal funct3 values: loads 000/001/010/100/101; stores 000/001/010.
  - Alignment: halfword requires a[0] = 0; word requires a[1:0] = 0.
  - An illegal or misaligned access raises no dmem_req, pulses mem_err, and forces RegWrite_WB = 0. It takes one cycle with no stall.
- FSM states:
  - IDLE, legal mem_op:
    - dmem_req = 1 combinationally, with dmem_addr = {a[31:2], 2'b00}.
    - If dmem_ready = 1: zero-wait completion; MEM/WB latches; state stays IDLE.
    - Else: stall = 1; next state WAIT; counter = 1.
  - WAIT:
    - dmem_req = 1; addr, be, wdata and we are held stable. stall = 1 until completion.
    - If dmem_ready = 1: stall = 0 in that cycle; MEM/WB latches; next state IDLE.
    - Else if counter = TIMEOUT: abort with dmem_req = 0, mem_err pulse, bubble to WB, stall = 0; next state IDLE.
    - Else: counter increments.
- Stall equation: stall = legal mem_op & ~dmem_ready & ~timeout_abort.
- MEM/WB register: loads every cycle. While stall = 1 it loads a bubble (RegWrite_WB = 0, MemtoReg_WB = 0). Otherwise it loads the EX/MEM fields plus the extended load data.
- Store lanes (lane = a[1:0]):
  - SB: be = 1 << lane; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 or 1100; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
- Load lanes:
  - Byte or halfword selected by lane from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Loads drive be = 1111.
- Forwarding and branch outputs come straight from the EX/MEM register, so they stay valid and stable during a stall.
- Reset mid-WAIT: state returns to IDLE, dmem_req drops immediately, stall = 0, and the access is lost.

Decomposition:
- Shared package core_pkg holds:
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - FSM state encoding: IDLE = 0, WAIT = 1.
  - TIMEOUT default.
- One combinational sub-module, load_store_align, contains the lane shift, byte enables, extension and the alignment/legality check.
- The pipeline registers and FSM stay in mem_stage.

Test Plan:
- Zero-wait LW:
  - Stimulus: a = 0x100, dmem_ready = 1 on the request cycle, rdata = 0xDEADBEEF.
  - Response: no stall; next cycle MEM_DATA_WB = 0xDEADBEEF, MemtoReg_WB = 1, RegWrite_WB = 1.
- LB sign-extend:
  - Stimulus: a = 0x103, rdata = 0x80123456.
  - Response: MEM_DATA_WB = 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH upper lane:
  - Stimulus: a = 0x102, rs2 = 0x1234ABCD.
  - Response: dmem_addr = 0x100, be = 1100, wdata = 0xABCDABCD, we = 1.
- 3-cycle wait:
  - Stimulus: dmem_ready low for 3 cycles.
  - Response: stall = 1 for exactly 3 cycles; addr/be/wdata stable; ALU_OUT_MEM stable; WB receives 3 bubbles, then the load.
- Misaligned and illegal accesses:
  - Stimulus: LW at 0x101, and a load with funct3 = 011.
  - Response: dmem_req = 0, one mem_err pulse each, RegWrite_WB = 0, no stall.
- Timeout and reset:
  - Stimulus: dmem_ready held at 0 with TIMEOUT = 16.
  - Response: stall for 16 cycles, then a mem_err pulse, dmem_req = 0, bubble.
  - Separately, reset asserted in WAIT clears stall and dmem_req in the same cycle.
